// File: rtl/lsu_bus_ctrl.sv
// Load/store bus controller: grant/rvalid bus sequencing, byte enables, stall.
// Optional bus watchdog enabled by defining LSU_TIMEOUT_EN.
module lsu_bus_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic [1:0]  offset_o,
    output logic [2:0]  funct3_o,
    output logic        misalign_o,
    output logic        bus_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state_q, state_d;
    logic        we_q;
    logic        legal, misal;
    logic        mis_set, err_set;
    logic        timeout;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;

    always_comb begin
        legal = 1'b0;
        unique case (1'b1)
            we_i:    legal = (funct3_i == 3'b000) || (funct3_i == 3'b001) ||
                             (funct3_i == 3'b010);
            default: legal = (funct3_i == 3'b000) || (funct3_i == 3'b001) ||
                             (funct3_i == 3'b010) || (funct3_i == 3'b100) ||
                             (funct3_i == 3'b101);
        endcase
        misal = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
    end

    always_comb begin
        be_d    = 4'b1111;
        wdata_d = wdata_i;
        if (we_i) begin
            case (funct3_i[1:0])
                2'b00: begin
                    be_d    = 4'b0001 << addr_i[1:0];
                    wdata_d = {4{wdata_i[7:0]}};
                end
                2'b01: begin
                    be_d    = 4'b0011 << addr_i[1:0];
                    wdata_d = {2{wdata_i[15:0]}};
                end
                default: begin
                    be_d    = 4'b1111;
                    wdata_d = wdata_i;
                end
            endcase
        end
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                        $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CW-1:0] cnt_q;

    // Counter value k means the (k+1)-th cycle spent in REQ/WAIT.
    assign timeout = ((state_q == REQ) || (state_q == WAIT)) &&
                     (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if ((state_d == REQ) && (state_q != REQ)) begin
            cnt_q <= '0;
        end else if ((state_q == REQ) || (state_q == WAIT)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        mis_set = 1'b0;
        err_set = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_i) begin
                    if (!legal) begin
                        state_d = DONE;
                        err_set = 1'b1;
                    end else if (misal) begin
                        state_d = DONE;
                        mis_set = 1'b1;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (mem_gnt_i) begin
                    state_d = WAIT;
                end else if (timeout) begin
                    state_d = DONE;
                    err_set = 1'b1;
                end
            end
            WAIT: begin
                // A response in the timeout cycle takes priority.
                if (mem_rvalid_i) begin
                    state_d = DONE;
                    err_set = mem_err_i;
                end else if (timeout) begin
                    state_d = DONE;
                    err_set = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q        <= 1'b0;
            offset_o    <= '0;
            funct3_o    <= '0;
            rdata_o     <= '0;
            misalign_o  <= 1'b0;
            bus_err_o   <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_be_o    <= '0;
            mem_wdata_o <= '0;
        end else begin
            misalign_o <= mis_set;
            bus_err_o  <= err_set;
            mem_req_o  <= (state_d == REQ);
            if ((state_q == IDLE) && req_i) begin
                we_q        <= we_i;
                offset_o    <= addr_i[1:0];
                funct3_o    <= funct3_i;
                mem_we_o    <= we_i;
                mem_addr_o  <= {addr_i[31:2], 2'b00};
                mem_be_o    <= be_d;
                mem_wdata_o <= wdata_d;
            end
            if ((state_q == WAIT) && mem_rvalid_i && !we_q) begin
                rdata_o <= mem_rdata_i;
            end
        end
    end

    assign done_o  = (state_q == DONE);
    assign stall_o = req_i && (state_q != DONE);

endmodule
